sparse_psum_row: RTL and testbench

Parametrised sparse multiply-accumulate row. It holds a block of non-zero weights, each tagged with an output-column index and an activation-slot index. It accumulates weight × activation products into a bank of partial sums across several parallel lanes, then presents the final partial sums through a valid/ready handshake. It sits between the activation/weight fetch logic and the psum drain path, and replaces the fixed two-tile, four-column row.

---
 rtl/sparse_psum_pkg.sv | 32 +++
 rtl/sparse_psum_row_if.sv | 33 +++
 rtl/sparse_psum_row_lane.sv | 39 +++
 rtl/sparse_psum_row.sv | 117 +++++++++++
 tb/tb_sparse_psum_row.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_psum_pkg.sv
// Shared types and arithmetic for the sparse psum row.
// SPARSE_PSUM_SAT_EN selects saturating accumulation; otherwise adds wrap.
package sparse_psum_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;

  function automatic int prod_w(input int bw);
    return 2 * bw + 1;
  endfunction

  // a and b arrive sign-extended from w bits; the result is again a w-bit value.
  function automatic wide_t psum_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
`ifdef SPARSE_PSUM_SAT_EN
    wide_t hi;
    wide_t lo;
    s  = a + b;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = ~hi;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`else
    s = a + b;
    s = (s <<< (MAXW - w)) >>> (MAXW - w);
`endif
    return s;
  endfunction

endpackage

// File: rtl/sparse_psum_row_if.sv
// Job and result bundle between the fetch logic, the psum row and the drain path.
// master drives a job and consumes the result; slave is the psum row itself.
interface sparse_psum_row_if #(
  parameter int NZ      = 8,
  parameter int BW      = 4,
  parameter int PSUM_BW = 20,
  parameter int COL     = 4,
  parameter int NACT    = 2
);
  localparam int IW = $clog2(COL);
  localparam int AW = (NACT > 1) ? $clog2(NACT) : 1;

  logic                          start;
  logic [NZ-1:0][BW-1:0]         nzero_weights;
  logic [NZ-1:0][IW-1:0]         w_indexes;
  logic [NZ-1:0][AW-1:0]         act_index;
  logic [NACT-1:0][BW-1:0]       in_activation;
  logic [COL-1:0][PSUM_BW-1:0]   in_psum;
  logic                          busy;
  logic                          out_valid;
  logic                          out_ready;
  logic [COL-1:0][PSUM_BW-1:0]   final_psum;

  modport master (
    output start, nzero_weights, w_indexes, act_index, in_activation, in_psum, out_ready,
    input  busy, out_valid, final_psum
  );

  modport slave (
    input  start, nzero_weights, w_indexes, act_index, in_activation, in_psum, out_ready,
    output busy, out_valid, final_psum
  );
endinterface

// File: rtl/sparse_psum_row_lane.sv
// One MAC lane: picks weight[step] of its K-slice, muxes its activation and forms
// a sign-extended product with its destination column; combinational only.
module sparse_psum_lane
  import sparse_psum_pkg::*;
#(
  parameter int K       = 4,
  parameter int BW      = 4,
  parameter int PSUM_BW = 20,
  parameter int COL     = 4,
  parameter int NACT    = 2,
  parameter int IW      = 2,
  parameter int AW      = 1,
  parameter int SW      = 2
) (
  input  logic [SW-1:0]             step,
  input  logic [K-1:0][BW-1:0]      weights,
  input  logic [K-1:0][IW-1:0]      cols,
  input  logic [K-1:0][AW-1:0]      slots,
  input  logic [NACT-1:0][BW-1:0]   act,
  output logic signed [PSUM_BW-1:0] prod,
  output logic [IW-1:0]             col,
  output logic                      vld
);
  localparam int PW = prod_w(BW);

  logic [AW-1:0]        slot;
  logic [BW-1:0]        a;
  logic signed [PW-1:0] p;

  always_comb begin
    slot = slots[step];
    // out-of-range slots fall back to activation 0
    a    = (32'(slot) < NACT) ? act[slot] : act[0];
    p    = PW'($signed(weights[step])) * PW'($signed({1'b0, a}));
    prod = PSUM_BW'(p);
    col  = cols[step];
    vld  = 32'(col) < COL;
  end
endmodule

// File: rtl/sparse_psum_row.sv
// Sparse MAC row: accept a job in IDLE, accumulate NCOL lanes for K cycles, hold the result
// until out_ready. Result visible K+1 cycles after start. SPARSE_PSUM_SAT_EN enables saturation.
module sparse_psum_row
  import sparse_psum_pkg::*;
#(
  parameter int NZ      = 8,
  parameter int BW      = 4,
  parameter int PSUM_BW = 20,
  parameter int NCOL    = 2,
  parameter int COL     = 4,
  parameter int NACT    = 2
) (
  input logic              clk,
  input logic              reset,
  sparse_psum_row_if.slave bus
);
  localparam int K  = NZ / NCOL;
  localparam int IW = $clog2(COL);
  localparam int AW = (NACT > 1) ? $clog2(NACT) : 1;
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  state_t state_q, state_nxt;
  logic [SW-1:0]               step_q;
  logic                        last_step;
  logic [NZ-1:0][BW-1:0]       w_q;
  logic [NZ-1:0][IW-1:0]       wi_q;
  logic [NZ-1:0][AW-1:0]       ai_q;
  logic [NACT-1:0][BW-1:0]     act_q;
  logic [COL-1:0][PSUM_BW-1:0] acc_q, acc_nxt, final_q;

  logic signed [PSUM_BW-1:0] lane_prod [NCOL];
  logic [IW-1:0]             lane_col  [NCOL];
  logic                      lane_vld  [NCOL];

  for (genvar i = 0; i < NCOL; i++) begin : g_lane
    sparse_psum_lane #(
      .K(K), .BW(BW), .PSUM_BW(PSUM_BW), .COL(COL), .NACT(NACT), .IW(IW), .AW(AW), .SW(SW)
    ) u_lane (
      .step    (step_q),
      .weights (w_q[i*K +: K]),
      .cols    (wi_q[i*K +: K]),
      .slots   (ai_q[i*K +: K]),
      .act     (act_q),
      .prod    (lane_prod[i]),
      .col     (lane_col[i]),
      .vld     (lane_vld[i])
    );
  end

  assign last_step = (step_q == SW'(K - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.final_psum = final_q;
  end

  // Lanes landing on the same column chain through acc_nxt in lane order.
  always_comb begin
    wide_t a_w, b_w, s_w;
    acc_nxt = acc_q;
    a_w = '0;
    b_w = '0;
    s_w = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (lane_vld[i]) begin
        a_w = wide_t'($signed(acc_nxt[lane_col[i]]));
        b_w = wide_t'(lane_prod[i]);
        s_w = psum_add(a_w, b_w, PSUM_BW);
        acc_nxt[lane_col[i]] = s_w[PSUM_BW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q  <= '0;
      acc_q   <= '0;
      final_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          w_q    <= bus.nzero_weights;
          wi_q   <= bus.w_indexes;
          ai_q   <= bus.act_index;
          act_q  <= bus.in_activation;
          acc_q  <= bus.in_psum;
          step_q <= '0;
        end
        RUN: begin
          acc_q  <= acc_nxt;
          step_q <= step_q + SW'(1);
          if (last_step) begin
            final_q <= acc_nxt;
            step_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse_psum_row.sv
// Bench for sparse_psum_row: directed jobs pinned to hand-computed results plus random
// cycle-by-cycle traffic, all checked every cycle against a behavioural job model.
module tb_sparse_psum_row;
  localparam int NZ = 8, BW = 4, PSUM_BW = 20, NCOL = 2, COL = 4, NACT = 2;
  localparam int K = NZ / NCOL;
`ifdef SPARSE_PSUM_SAT_EN
  localparam longint SAT_EXP = 524287;
`else
  localparam longint SAT_EXP = -523869;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sparse_psum_row_if #(.NZ(NZ), .BW(BW), .PSUM_BW(PSUM_BW), .COL(COL), .NACT(NACT)) bus ();

  sparse_psum_row #(
    .NZ(NZ), .BW(BW), .PSUM_BW(PSUM_BW), .NCOL(NCOL), .COL(COL), .NACT(NACT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     chk_en  = 0;

  // job as seen by the bench
  int     jw  [NZ];
  int     jwi [NZ];
  int     jai [NZ];
  int     jact[NACT];
  longint jps [COL];

  // model state
  bit     m_busy = 0, m_valid = 0;
  int     m_cnt = 0, m_jobs = 0;
  longint m_res [COL];
  longint m_psum[COL];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fit(input longint v);
    longint half = longint'(1) <<< (PSUM_BW - 1);
`ifdef SPARSE_PSUM_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    longint r = v & (2 * half - 1);
    if (r >= half) r -= 2 * half;
    return r;
`endif
  endfunction

  function automatic void compute();
    for (int c = 0; c < COL; c++) m_res[c] = fit(jps[c]);
    for (int s = 0; s < K; s++)
      for (int i = 0; i < NCOL; i++) begin
        int j = i * K + s;
        int a = (jai[j] < NACT) ? jact[jai[j]] : jact[0];
        if (jwi[j] < COL) m_res[jwi[j]] = fit(m_res[jwi[j]] + longint'(jw[j] * a));
      end
  endfunction

  function automatic longint fp(input int c);
    return longint'($signed(bus.final_psum[c]));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      for (int c = 0; c < COL; c++) m_psum[c] = 0;
    end else if (!m_busy) begin
      if (bus.start) begin m_busy = 1; m_cnt = K; compute(); end
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) begin m_valid = 1; m_psum = m_res; end
    end else if (bus.out_ready) begin
      m_busy = 0; m_valid = 0; m_jobs++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy", bus.busy, m_busy);
      chk("cmp_valid", bus.out_valid, m_valid);
      for (int c = 0; c < COL; c++) chk("cmp_final", fp(c), m_psum[c]);
    end
  end

  task automatic drive();
    for (int j = 0; j < NZ; j++) begin
      bus.nzero_weights[j] = BW'(jw[j]);
      bus.w_indexes[j]     = 2'(jwi[j]);
      bus.act_index[j]     = 1'(jai[j]);
    end
    for (int a = 0; a < NACT; a++) bus.in_activation[a] = BW'(jact[a]);
    for (int c = 0; c < COL; c++)  bus.in_psum[c] = PSUM_BW'(jps[c]);
  endtask

  task automatic set_lanes(input int w0, input int c0, input int s0, input int w1, input int c1, input int s1);
    for (int s = 0; s < K; s++) begin
      jw[s] = w0;     jwi[s] = c0;     jai[s] = s0;
      jw[K+s] = w1;   jwi[K+s] = c1;   jai[K+s] = s1;
    end
  endtask

  task automatic set_basic();
    set_lanes(1, 0, 0, 2, 1, 1);
    jact[0] = 3; jact[1] = 5;
    for (int c = 0; c < COL; c++) jps[c] = 0;
    drive();
  endtask

  task automatic set_sat();
    set_lanes(7, 0, 0, 0, 1, 1);
    jact[0] = 15; jact[1] = 0;
    jps[0] = 524287; jps[1] = 0; jps[2] = 0; jps[3] = 0;
    drive();
  endtask

  task automatic set_random();
    for (int j = 0; j < NZ; j++) begin
      jw[j] = int'($urandom_range(15)) - 8;
      jwi[j] = int'($urandom_range(COL - 1));
      jai[j] = int'($urandom_range(NACT - 1));
    end
    for (int a = 0; a < NACT; a++) jact[a] = int'($urandom_range(15));
    for (int c = 0; c < COL; c++) begin
      jps[c] = longint'($urandom_range((1 << PSUM_BW) - 1)) - (longint'(1) << (PSUM_BW - 1));
      if ($urandom_range(3) == 0) jps[c] = $urandom_range(1) ? 524280 : -524280;
    end
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    chk(name, bus.out_valid, 1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_basic(input string name);
    chk({name, "_c0"}, fp(0), 12);
    chk({name, "_c1"}, fp(1), 40);
    chk({name, "_c2"}, fp(2), 0);
    chk({name, "_c3"}, fp(3), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    set_basic();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_final0", fp(0), 0);

    // basic job with latency check
    tick();
    set_basic();
    pulse_start();
    chk("basic_busy", bus.busy, 1);
    repeat (3) tick();
    chk("latency_pre", bus.out_valid, 0);
    tick();
    chk("latency_at", bus.out_valid, 1);
    chk_basic("basic");
    chk("model_basic", m_psum[1], 40);
    handshake();
    chk("basic_idle", bus.busy, 0);

    // collision on column 2
    set_lanes(1, 2, 0, -2, 2, 1);
    jact[0] = 3; jact[1] = 5;
    jps[0] = 11; jps[1] = -5; jps[2] = 100; jps[3] = 33;
    drive();
    pulse_start();
    wait_valid("coll_timeout");
    chk("coll_c0", fp(0), 11);
    chk("coll_c1", fp(1), -5);
    chk("coll_c2", fp(2), 72);
    chk("coll_c3", fp(3), 33);
    chk("model_coll", m_psum[2], 72);
    handshake();

    // saturation / wrap at top of range
    set_sat();
    pulse_start();
    wait_valid("sat_timeout");
    chk("sat_c0", fp(0), SAT_EXP);
    chk("sat_c1", fp(1), 0);
    chk("model_sat", m_psum[0], SAT_EXP);
    handshake();

    // backpressure with a start pulse that must be ignored
    set_basic();
    pulse_start();
    wait_valid("bp_timeout");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin set_sat(); bus.start = 1'b1; end
      else bus.start = 1'b0;
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_hold", fp(1), 40);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_idle", bus.busy, 0);
    pulse_start();
    chk("bp_restart", bus.busy, 1);
    wait_valid("bp2_timeout");
    chk("bp_sat_c0", fp(0), SAT_EXP);
    handshake();

    // reset while step 2 is in progress
    set_basic();
    pulse_start();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_busy", bus.busy, 0);
    for (int c = 0; c < COL; c++) chk("mrst_final", fp(c), 0);
    pulse_start();
    wait_valid("mrst_timeout");
    chk_basic("mrst_job");
    handshake();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_random();
      bus.start = ($urandom_range(2) == 0);
      bus.out_ready = ($urandom_range(1) == 1);
      tick();
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    chk("random_jobs_done", (m_jobs >= 20) ? 1 : 0, 1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
